ifetch_queued: RTL
==================

// Module: ifetch_queued
// PURPOSE
//  Parametrised instruction-fetch stage with a prefetch queue; replaces the fixed
//  one-deep IF/ID buffer. Drives a 1-cycle-latency synchronous instruction memory
//  and holds fetched {nPC, IR} pairs until decode accepts them.
//  Adds decode back-pressure (stall) and branch redirect with queue flush.
// PARAMETERS
//  WIDTH     32   address/instruction width in bits
//  STEP      4    PC increment per instruction
//  QDEPTH    4    prefetch queue entries; must be >= 3 for one instruction/cycle
//  RESET_PC  0    PC value loaded on reset
// PORTS
//  clk        in   1      clock, all state updates on rising edge
//  reset      in   1      synchronous, active-high
//  PCSrc      in   1      redirect: fetch from BrDest and flush queued work
//  BrDest     in   WIDTH  redirect target address
//  stall      in   1      decode cannot accept head entry this cycle
//  imem_en    out  1      memory read request this cycle
//  imem_addr  out  WIDTH  request address
//  imem_rdata in   WIDTH  data for the request issued in the previous cycle
//  nPC        out  WIDTH  head entry: fetch address + STEP
//  IR         out  WIDTH  head entry: instruction word
//  valid      out  1      head entry present
// BEHAVIOUR
//  - Reset: PC=RESET_PC, queue empty, in-flight flag=0, valid=0, nPC=0, IR=0,
//    imem_en=0. First request in the first cycle with reset low.
//  - Issue: imem_en = !reset && (PCSrc || (count + inflight) < QDEPTH).
//    imem_addr = PCSrc ? BrDest : PC. On issue PC <= imem_addr + STEP (mod 2^WIDTH).
//    Pop in the same cycle is not counted toward room (conservative).
//  - Response: inflight <= imem_en each cycle; inflight_addr <= imem_addr.
//    While inflight=1, {inflight_addr+STEP, imem_rdata} is pushed at the clock edge
//    unless dropped by a flush. Room is guaranteed by issue rule; no overflow.
//  - Output: nPC/IR driven from the queue head register; valid = (count != 0).
//    Pop at edge when valid && !stall. Push and pop in the same cycle: count unchanged.
//  - Latency: request in T -> entry visible (valid=1) in T+2.
//  - Flush (PCSrc=1 in cycle T): queue emptied, the response arriving in T is dropped,
//    valid=0 in T+1; BrDest is requested in T itself, so target valid in T+2.
//  - PCSrc together with stall: flush wins; stalled head is discarded.
//  - Stall held: queue fills to QDEPTH, issue stops; resumes the cycle after count
//    drops. Held entries and nPC/IR stable while stall=1.
//  - Reset asserted mid-operation: everything returns to reset state at that edge;
//    any in-flight response is ignored.
//  - Queue: circular buffer, head/tail pointers wrap at QDEPTH (non-power-of-2 legal),
//    count width $clog2(QDEPTH+1).
// CONFIGURATION
//  IFETCH_PERF_EN defined: extra output ports perf_fetch, perf_stall, perf_flush
//    (32 bits each, wrap on overflow, cleared by reset): count cycles with imem_en=1,
//    cycles with valid && stall, cycles with PCSrc=1 respectively.
//  IFETCH_PERF_EN undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1 Reset release, stall=0, memory word[a]=a: addr 0,4,8 issued in cycles 0,1,2;
//    valid from cycle 2 with IR=0,nPC=4 then IR=4,nPC=8; one entry per cycle.
//  2 Stall held 10 cycles from steady state: count reaches 4, imem_en=0 while full,
//    head IR unchanged; release -> entries drain in order, no gap, no lost/duplicated PC.
//  3 PCSrc=1, BrDest=0x100 in cycle T: imem_addr=0x100 in T, valid=0 in T+1,
//    IR=0x100, nPC=0x104 in T+2; no older instruction appears after T.
//  4 PCSrc=1 with stall=1 and full queue: queue flushed, BrDest entry at T+2.
//  5 RESET_PC=0xFFFFFFF8: fetch 0xFFFFFFF8, 0xFFFFFFFC, 0x0 (wrap), nPC of
//    second = 0x0.
//  6 Reset pulsed mid-stream with inflight=1: valid=0 next cycle, first request
//    RESET_PC; with IFETCH_PERF_EN, counters read 0 after reset and match
//    issued/stalled/flushed cycle totals across scenarios 1-4.

Source files
------------

// File: rtl/ifetch_queued_if.sv
// Fetch-stage bus: decode/redirect controls, imem port, head entry.
// master = fetch stage, slave = surrounding pipeline and memory.
interface ifetch_queued_if #(
  parameter int WIDTH = 32
);
  logic             PCSrc;
  logic [WIDTH-1:0] BrDest;
  logic             stall;
  logic             imem_en;
  logic [WIDTH-1:0] imem_addr;
  logic [WIDTH-1:0] imem_rdata;
  logic [WIDTH-1:0] nPC;
  logic [WIDTH-1:0] IR;
  logic             valid;

  modport master (
    input  PCSrc, BrDest, stall, imem_rdata,
    output imem_en, imem_addr, nPC, IR, valid
  );

  modport slave (
    output PCSrc, BrDest, stall, imem_rdata,
    input  imem_en, imem_addr, nPC, IR, valid
  );
endinterface

// File: rtl/ifetch_queued.sv
// Instruction fetch with prefetch queue, stall and redirect flush.
// IFETCH_PERF_EN adds perf_fetch/perf_stall/perf_flush counters.
module ifetch_queued #(
  parameter int               WIDTH    = 32,
  parameter int               STEP     = 4,
  parameter int               QDEPTH   = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
`ifdef IFETCH_PERF_EN
  output logic [31:0]  perf_fetch,
  output logic [31:0]  perf_stall,
  output logic [31:0]  perf_flush,
`endif
  ifetch_queued_if.master bus
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  typedef logic [PW-1:0] ptr_t;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             infl_q;
  logic [WIDTH-1:0] infl_addr_q;
  logic [CW-1:0]    count_q, count_d;
  ptr_t             head_q, head_d;
  ptr_t             tail_q, tail_d;
  logic [WIDTH-1:0] npc_q [QDEPTH];
  logic [WIDTH-1:0] ir_q  [QDEPTH];

  logic             room, issue, push, pop, valid;
  logic [WIDTH-1:0] addr;

  function automatic ptr_t nxt(input ptr_t p);
    return (p == ptr_t'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid = (count_q != '0);

  always_comb begin
    room    = ({1'b0, count_q} + {{CW{1'b0}}, infl_q})
              < (CW+1)'(QDEPTH);
    issue   = !reset && (bus.PCSrc || room);
    addr    = bus.PCSrc ? bus.BrDest : pc_q;
    push    = infl_q && !bus.PCSrc;
    pop     = valid && !bus.stall && !bus.PCSrc;
    pc_d    = issue ? addr + WIDTH'(STEP) : pc_q;
    count_d = count_q;
    head_d  = pop ? nxt(head_q) : head_q;
    tail_d  = push ? nxt(tail_q) : tail_q;
    unique case (1'b1)
      push && !pop: count_d = count_q + 1'b1;
      pop && !push: count_d = count_q - 1'b1;
      default:      count_d = count_q;
    endcase
    // Redirect drops the queue and the response landing this cycle
    if (bus.PCSrc) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      infl_q      <= 1'b0;
      infl_addr_q <= '0;
      count_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      pc_q        <= pc_d;
      infl_q      <= issue;
      infl_addr_q <= addr;
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      if (push) begin
        npc_q[tail_q] <= infl_addr_q + WIDTH'(STEP);
        ir_q[tail_q]  <= bus.imem_rdata;
      end
    end
  end

  assign bus.imem_en   = issue;
  assign bus.imem_addr = addr;
  assign bus.valid     = valid;
  assign bus.nPC       = valid ? npc_q[head_q] : '0;
  assign bus.IR        = valid ? ir_q[head_q] : '0;

`ifdef IFETCH_PERF_EN
  logic [31:0] pf_q, ps_q, pl_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pf_q <= '0;
      ps_q <= '0;
      pl_q <= '0;
    end else begin
      pf_q <= pf_q + {31'd0, issue};
      ps_q <= ps_q + {31'd0, valid && bus.stall};
      pl_q <= pl_q + {31'd0, bus.PCSrc};
    end
  end

  assign perf_fetch = pf_q;
  assign perf_stall = ps_q;
  assign perf_flush = pl_q;
`endif

endmodule
